step_counter: RTL
=================

STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 SHALL have parameter CLKS_PER_SEC, default 100000000, clk cycles per one-second activity window.
REQ-002 SHALL have parameter STEP_MAX, default 9999, saturation ceiling for every reported value (4-digit display limit).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port step  input  1  single-cycle step pulse, already debounced and single-pulsed.
REQ-006 SHALL have port mode  input  2  display selection: 0 total steps, 1 distance, 2 early-activity seconds, 3 peak rate.
REQ-007 SHALL have port current_count  output  16  registered binary value sent downstream to the 4-digit seven-segment driver.
REQ-008 SHALL have port sec_tick  output  1  one-cycle pulse on the last clk of each one-second window.

Function
REQ-009 SHALL keep a prescaler counting 0..CLKS_PER_SEC-1 and wrapping to 0; sec_tick = 1 exactly when the prescaler equals CLKS_PER_SEC-1.
REQ-010 SHALL keep total_steps (14 bits), incremented by 1 on each cycle with step=1, holding at STEP_MAX (no wrap).
REQ-011 SHALL keep win_steps, the step count in the current window; it increments like total_steps (saturating at 16383) and loads 0 on sec_tick.
REQ-012 A step on the same cycle as sec_tick SHALL count toward the window that is closing; the new window then starts at 0.
REQ-013 SHALL keep sec_index (0..9, saturating at 9), incremented on each sec_tick.
REQ-014 On sec_tick with sec_index < 9, SHALL increment early_active (0..9) if the closing window's total, including a coincident step, is > 32.
REQ-015 On sec_tick, SHALL set peak_rate = max(peak_rate, closing window total incl. coincident step), capped at STEP_MAX.
REQ-016 Distance SHALL be floor(total_steps*10/2048), in tenths of a mile at 2048 steps/mile: the product is formed at >= 18 bits, then shifted right 11; 9999 steps -> 48.
REQ-017 current_count SHALL be registered and equal, one cycle after any change of its source or of mode: mode0 total_steps, mode1 distance, mode2 early_active, mode3 peak_rate, zero-extended to 16 bits.
REQ-018 Latency: a step at cycle N SHALL be visible on current_count (mode 0) at cycle N+1.
REQ-019 Mode change SHALL not alter any counter; only the output mux selection changes.
REQ-020 No arithmetic result SHALL wrap; all counters saturate at the ceilings stated.

Reset
REQ-021 While reset=1 at posedge clk: prescaler, total_steps, win_steps, sec_index, early_active, peak_rate, current_count, sec_tick SHALL all be set to 0.
REQ-022 A step coincident with reset SHALL be ignored.
REQ-023 Reset mid-window SHALL restart the prescaler, so the first sec_tick after release occurs CLKS_PER_SEC cycles after the last reset cycle.
REQ-024 reset SHALL take priority over step, sec_tick and mode in every cycle.

Verification (CLKS_PER_SEC=10 for bench)
REQ-025 reset, then mode=0 and 5 step pulses -> current_count=5, each increment one cycle after its pulse.
REQ-026 preload total via 9999 pulses, then 3 more -> mode0 holds 9999; mode1 reads 48.
REQ-027 40 steps in window 1, 10 in window 2, 33 in window 3 -> after the 3rd sec_tick: mode2=2, mode3=40.
REQ-028 step asserted on the sec_tick cycle of a window with 32 prior steps -> closing total 33, early_active increments, next window win_steps starts 0.
REQ-029 reset asserted mid-window with 7 steps and early_active=3 -> all outputs 0 next cycle; next sec_tick exactly 10 cycles after reset deasserts.
REQ-030 run 12 windows of 50 steps -> mode2 saturates at 9, sec_index holds at 9, mode3=50.

Source files
------------

// File: rtl/step_counter.sv
// step_counter: pedometer with saturating totals, one-second activity windows
// and a registered display mux for a 4-digit seven-segment driver.
module step_counter #(
   parameter int CLKS_PER_SEC = 100000000,
   parameter int STEP_MAX     = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   input  logic [1:0]  mode,
   output logic [15:0] current_count,
   output logic        sec_tick
);
   localparam int PW = CLKS_PER_SEC > 1 ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_SEC - 1);
   localparam logic [13:0] SMAX = 14'(STEP_MAX);
   logic [PW-1:0] presc_q, presc_d;
   logic [13:0]   tot_q, tot_d, win_q, win_d, peak_q, peak_d, close_w, close_cap;
   logic [3:0]    sec_q, sec_d, early_q, early_d;
   logic [17:0]   dist_p;
   logic [15:0]   cc_q, cc_d;
   logic          tick;
   assign tick = presc_q == PMAX;
   assign sec_tick = tick;
   assign current_count = cc_q;
   // close_w is the closing window total including a step on the tick cycle
   always_comb begin
      presc_d   = tick ? '0 : presc_q + PW'(1);
      tot_d     = (step && tot_q < SMAX) ? tot_q + 14'd1 : tot_q;
      close_w   = (step && win_q != '1) ? win_q + 14'd1 : win_q;
      close_cap = close_w > SMAX ? SMAX : close_w;
      win_d     = tick ? '0 : close_w;
      sec_d     = (tick && sec_q < 4'd9) ? sec_q + 4'd1 : sec_q;
      early_d   = (tick && sec_q < 4'd9 && close_w > 14'd32) ? early_q + 4'd1 : early_q;
      peak_d    = (tick && close_cap > peak_q) ? close_cap : peak_q;
      dist_p    = 18'(tot_d) * 18'd10;
      cc_d      = mode == 2'd0 ? 16'(tot_d) :
                  mode == 2'd1 ? 16'(dist_p >> 11) :
                  mode == 2'd2 ? 16'(early_d) : 16'(peak_d);
   end
   // the display register follows next-state values so a step shows one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         tot_q   <= '0;
         win_q   <= '0;
         sec_q   <= '0;
         early_q <= '0;
         peak_q  <= '0;
         cc_q    <= '0;
      end else begin
         presc_q <= presc_d;
         tot_q   <= tot_d;
         win_q   <= win_d;
         sec_q   <= sec_d;
         early_q <= early_d;
         peak_q  <= peak_d;
         cc_q    <= cc_d;
      end
   end
endmodule
